// File: rtl/uart_responder.sv
`default_nettype none
// ============================================================================
// Module   : uart_responder
// Summary  : CPU-facing UART endpoint: one-byte THR/RBR, 8N1 serializer and
//            deserializer, rdn/wrn strobe handshake on the shared data bus.
// Revision : 1.0
// ============================================================================
module uart_responder #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       CLK,
    input  logic       RST,
    inout  wire  [7:0] data_io,
    input  logic       rdn,
    input  logic       wrn,
    output logic       data_ready,
    output logic       tbre,
    output logic       tsre,
    output logic       txd,
    input  logic       rxd
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] c_bit_last  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] c_half_last = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    logic          r_rdn_q, r_wrn_q;
    logic          r_tbre, r_dr;
    logic [7:0]    r_thr, r_rbr;
    logic          r_rx_meta, r_rx_s;
    logic          w_wr_stb, w_rd_end;

    state_t        r_tx_state, w_tx_state_n;
    logic [CW-1:0] r_tx_cnt, w_tx_cnt_n;
    logic [3:0]    r_tx_bit, w_tx_bit_n;
    logic [7:0]    r_tsr, w_tsr_n;
    logic          r_txd, w_txd_n, r_tsre, w_tsre_n, w_tx_load;

    state_t        r_rx_state, w_rx_state_n;
    logic [CW-1:0] r_rx_cnt, w_rx_cnt_n;
    logic [3:0]    r_rx_bit, w_rx_bit_n;
    logic [7:0]    r_rx_shift, w_rx_shift_n;
    logic          w_rx_ok;

    assign w_wr_stb   = r_wrn_q & ~wrn;
    assign w_rd_end   = ~r_rdn_q & rdn;
    assign data_io    = rdn ? 8'hzz : r_rbr;
    assign data_ready = r_dr;
    assign tbre       = r_tbre;
    assign tsre       = r_tsre;
    assign txd        = r_txd;

    // Strobe edge detect, holding/receive registers and status flags
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_rdn_q   <= 1'b1;
            r_wrn_q   <= 1'b1;
            r_tbre    <= 1'b1;
            r_thr     <= 8'h00;
            r_rbr     <= 8'h00;
            r_dr      <= 1'b0;
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rdn_q   <= rdn;
            r_wrn_q   <= wrn;
            r_rx_meta <= rxd;
            r_rx_s    <= r_rx_meta;
            if (w_tx_load) begin
                r_tbre <= 1'b1;
            end else if (w_wr_stb && r_tbre) begin
                r_tbre <= 1'b0;
                r_thr  <= data_io;
            end
            if (w_rx_ok) begin
                r_rbr <= r_rx_shift;
                r_dr  <= 1'b1;
            end else if (w_rd_end) begin
                r_dr  <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_tx_state <= S_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= 4'd0;
            r_tsr      <= 8'h00;
            r_txd      <= 1'b1;
            r_tsre     <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_n;
            r_tx_cnt   <= w_tx_cnt_n;
            r_tx_bit   <= w_tx_bit_n;
            r_tsr      <= w_tsr_n;
            r_txd      <= w_txd_n;
            r_tsre     <= w_tsre_n;
        end
    end

    // txd is registered, so each state sets the level of the next bit on its last cycle
    always_comb begin
        w_tx_state_n = r_tx_state;
        w_tx_cnt_n   = r_tx_cnt;
        w_tx_bit_n   = r_tx_bit;
        w_tsr_n      = r_tsr;
        w_txd_n      = r_txd;
        w_tsre_n     = r_tsre;
        w_tx_load    = 1'b0;
        case (r_tx_state)
            S_IDLE: begin
                if (!r_tbre && r_tsre) begin
                    w_tx_load    = 1'b1;
                    w_tsr_n      = r_thr;
                    w_tsre_n     = 1'b0;
                    w_txd_n      = 1'b0;
                    w_tx_cnt_n   = '0;
                    w_tx_state_n = S_START;
                end
            end
            S_START: begin
                if (r_tx_cnt == c_bit_last) begin
                    w_tx_cnt_n   = '0;
                    w_tx_bit_n   = 4'd0;
                    w_txd_n      = r_tsr[0];
                    w_tx_state_n = S_DATA;
                end else begin
                    w_tx_cnt_n = r_tx_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (r_tx_cnt == c_bit_last) begin
                    w_tx_cnt_n = '0;
                    w_tsr_n    = {1'b0, r_tsr[7:1]};
                    if (r_tx_bit == 4'd7) begin
                        w_txd_n      = 1'b1;
                        w_tx_state_n = S_STOP;
                    end else begin
                        w_txd_n    = r_tsr[1];
                        w_tx_bit_n = r_tx_bit + 1'b1;
                    end
                end else begin
                    w_tx_cnt_n = r_tx_cnt + 1'b1;
                end
            end
            S_STOP: begin
                if (r_tx_cnt == c_bit_last) begin
                    w_tx_cnt_n   = '0;
                    w_tsre_n     = 1'b1;
                    w_tx_state_n = S_IDLE;
                end else begin
                    w_tx_cnt_n = r_tx_cnt + 1'b1;
                end
            end
            default: w_tx_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_rx_state <= S_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= 4'd0;
            r_rx_shift <= 8'h00;
        end else begin
            r_rx_state <= w_rx_state_n;
            r_rx_cnt   <= w_rx_cnt_n;
            r_rx_bit   <= w_rx_bit_n;
            r_rx_shift <= w_rx_shift_n;
        end
    end

    // Half-bit wait in START aligns all later samples to mid-bit
    always_comb begin
        w_rx_state_n = r_rx_state;
        w_rx_cnt_n   = r_rx_cnt;
        w_rx_bit_n   = r_rx_bit;
        w_rx_shift_n = r_rx_shift;
        w_rx_ok      = 1'b0;
        case (r_rx_state)
            S_IDLE: begin
                if (!r_rx_s) begin
                    w_rx_cnt_n   = '0;
                    w_rx_state_n = S_START;
                end
            end
            S_START: begin
                if (r_rx_cnt == c_half_last) begin
                    w_rx_cnt_n   = '0;
                    w_rx_bit_n   = 4'd0;
                    w_rx_state_n = r_rx_s ? S_IDLE : S_DATA;
                end else begin
                    w_rx_cnt_n = r_rx_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (r_rx_cnt == c_bit_last) begin
                    w_rx_cnt_n   = '0;
                    w_rx_shift_n = {r_rx_s, r_rx_shift[7:1]};
                    if (r_rx_bit == 4'd7) begin
                        w_rx_state_n = S_STOP;
                    end else begin
                        w_rx_bit_n = r_rx_bit + 1'b1;
                    end
                end else begin
                    w_rx_cnt_n = r_rx_cnt + 1'b1;
                end
            end
            S_STOP: begin
                if (r_rx_cnt == c_bit_last) begin
                    w_rx_cnt_n   = '0;
                    w_rx_ok      = r_rx_s;
                    w_rx_state_n = S_IDLE;
                end else begin
                    w_rx_cnt_n = r_rx_cnt + 1'b1;
                end
            end
            default: w_rx_state_n = S_IDLE;
        endcase
    end
endmodule
`default_nettype wire
